// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types and helpers for the two-master RAM port arbiter
package ram_arb_pkg;

  localparam int NUM_MASTERS = 2;

  // Master identity doubles as the bit index into the req/gnt vectors
  typedef enum logic {
    M_INSTR = 1'b0,
    M_DATA  = 1'b1
  } master_e;

  // One RAM access as presented on the RAM port
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } ram_cmd_t;

  // Window check in 33 bits: an address below base borrows into bit 32 and lands out of range
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] span);
    logic [32:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return offset < span;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - bundle of both master request buses and the RAM port
interface ram_port_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic        ram_req;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_addr,
    input  d_req, d_addr, d_we, d_be, d_wdata,
    input  ram_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output ram_req, ram_addr, ram_we, ram_be, ram_wdata
  );

  // Requesters plus RAM side
  modport master (
    output i_req, i_addr,
    output d_req, d_addr, d_we, d_be, d_wdata,
    output ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  ram_req, ram_addr, ram_we, ram_be, ram_wdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr.sv
// rtl/ram_port_arbiter_rr.sv - two-way round-robin grant with last-winner register
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req_i,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  master_e rr_last_q;
  master_e rr_last_d;

  // Grant: a lone requester wins outright, a tie goes to whoever did not win last
  always_comb begin
    gnt_o     = '0;
    rr_last_d = rr_last_q;
    if (rst_n) begin
      if (req_i[M_INSTR] && req_i[M_DATA]) begin
        if (rr_last_q == M_INSTR) gnt_o[M_DATA]  = 1'b1;
        else                      gnt_o[M_INSTR] = 1'b1;
      end else begin
        gnt_o = req_i;
      end
      if (gnt_o[M_DATA])       rr_last_d = M_DATA;
      else if (gnt_o[M_INSTR]) rr_last_d = M_INSTR;
    end
  end

  // Last-winner register; reset favours the data master on the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) rr_last_q <= M_INSTR;
    else        rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin instr/data front end for the single-port SoC RAM
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_port_arbiter_if.slave  bus
);

  localparam logic [32:0] WIN_BYTES = 33'(DEPTH) * 33'd4;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt;
  master_e                winner;
  logic                   granted;
  logic                   in_range;
  ram_cmd_t               cmd;

  logic    rsp_valid_q, rsp_valid_d;
  master_e rsp_owner_q, rsp_owner_d;
  logic    rsp_err_q,   rsp_err_d;
  logic    rsp_we_q,    rsp_we_d;
  logic [31:0] rsp_rdata;

  assign req[M_INSTR] = bus.i_req;
  assign req[M_DATA]  = bus.d_req;

  ram_arb_rr u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  // Command mux from the winner; the instr master is a fixed full-word reader
  always_comb begin
    granted = |gnt;
    winner  = gnt[M_DATA] ? M_DATA : M_INSTR;
    if (winner == M_DATA) begin
      cmd.addr  = bus.d_addr;
      cmd.we    = bus.d_we;
      cmd.be    = bus.d_be;
      cmd.wdata = bus.d_wdata;
    end else begin
      cmd.addr  = bus.i_addr;
      cmd.we    = 1'b0;
      cmd.be    = 4'hF;
      cmd.wdata = '0;
    end
    in_range = in_window(cmd.addr, BASE_ADDR, WIN_BYTES);
  end

  // RAM port: out-of-window accesses are granted but never reach the RAM
  always_comb begin
    bus.i_gnt     = gnt[M_INSTR];
    bus.d_gnt     = gnt[M_DATA];
    bus.ram_req   = granted & in_range;
    bus.ram_addr  = cmd.addr;
    bus.ram_we    = cmd.we;
    bus.ram_be    = cmd.be;
    bus.ram_wdata = cmd.wdata;
  end

  // Response stage next state: remember who was granted and what kind of access it was
  always_comb begin
    rsp_valid_d = granted;
    rsp_owner_d = winner;
    rsp_err_d   = granted & ~in_range;
    rsp_we_d    = cmd.we;
  end

  // Response register; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= M_INSTR;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  // Response demux: only the owner sees rvalid; data passes only for in-window reads
  always_comb begin
    rsp_rdata    = (rsp_err_q || rsp_we_q) ? 32'h0 : bus.ram_rdata;
    bus.i_rvalid = rst_n & rsp_valid_q & (rsp_owner_q == M_INSTR);
    bus.d_rvalid = rst_n & rsp_valid_q & (rsp_owner_q == M_DATA);
    bus.i_err    = bus.i_rvalid & rsp_err_q;
    bus.d_err    = bus.d_rvalid & rsp_err_q;
    bus.i_rdata  = bus.i_rvalid ? rsp_rdata : 32'h0;
    bus.d_rdata  = bus.d_rvalid ? rsp_rdata : 32'h0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - randomized and directed checks of ram_port_arbiter against a behavioural model
module tb_ram_port_arbiter;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_port_arbiter_if bus ();

  ram_port_arbiter #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural RAM attached to the RAM port
  logic [31:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.ram_req) begin
      if (bus.ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be[b]) ram_mem[bus.ram_addr[13:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
        bus.ram_rdata <= 32'h0;
      end else begin
        bus.ram_rdata <= ram_mem[bus.ram_addr[13:2]];
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_last;      // 0 = instr won last, 1 = data won last
  bit          p_valid;
  int          p_owner;
  bit          p_err;
  logic [31:0] p_rdata;

  bit          m_granted, m_inr, m_we;
  int          m_win;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  longint      m_off;

  logic        exp_ig, exp_dg, exp_rreq;
  logic        exp_irv, exp_drv, exp_ierr, exp_derr;
  logic [31:0] exp_ird, exp_drd;

  task automatic model_predict();
    exp_ig = 0; exp_dg = 0; exp_rreq = 0;
    exp_irv = 0; exp_drv = 0; exp_ierr = 0; exp_derr = 0;
    exp_ird = 0; exp_drd = 0;
    m_granted = 0;
    if (rst_n) begin
      exp_irv  = p_valid && p_owner == 0;
      exp_drv  = p_valid && p_owner == 1;
      exp_ierr = exp_irv && p_err;
      exp_derr = exp_drv && p_err;
      exp_ird  = exp_irv ? p_rdata : 32'h0;
      exp_drd  = exp_drv ? p_rdata : 32'h0;
      m_granted = bus.i_req || bus.d_req;
      if (bus.i_req && bus.d_req) m_win = (m_last == 0) ? 1 : 0;
      else                        m_win = bus.d_req ? 1 : 0;
      m_addr  = m_win == 1 ? bus.d_addr : bus.i_addr;
      m_we    = m_win == 1 ? bus.d_we : 1'b0;
      m_be    = m_win == 1 ? bus.d_be : 4'hF;
      m_wdata = m_win == 1 ? bus.d_wdata : 32'h0;
      m_off   = longint'(m_addr) - longint'(BASE);
      m_inr   = m_off >= 0 && m_off < longint'(DEPTH) * 4;
      exp_ig   = m_granted && m_win == 0;
      exp_dg   = m_granted && m_win == 1;
      exp_rreq = m_granted && m_inr;
    end
  endtask

  task automatic model_commit();
    int idx;
    if (!rst_n) begin
      m_last  = 0;
      p_valid = 0;
    end else begin
      p_valid = m_granted;
      if (m_granted) begin
        m_last  = m_win;
        p_owner = m_win;
        p_err   = !m_inr;
        p_rdata = 32'h0;
        if (m_inr) begin
          idx = int'(m_off / 4);
          if (m_we) begin
            for (int b = 0; b < 4; b++)
              if (m_be[b]) ref_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
          end else begin
            p_rdata = ref_mem[idx];
          end
        end
      end
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic dw, input logic [3:0] db,
                       input logic [31:0] dd);
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_addr = da; bus.d_we = dw; bus.d_be = db; bus.d_wdata = dd;
  endtask

  task automatic settle();
    @(negedge clk);
    model_predict();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)      return 32'($urandom_range(0, DEPTH * 4 - 1));
    else if (r < 9) return 32'h4000 + 32'($urandom_range(0, 255) * 4);
    else            return $urandom | 32'h8000_0000;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 32'h0, 1, 32'h4, 0, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      settle();
      vectors++;
      if ({bus.i_gnt, bus.d_gnt, bus.ram_req} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_gnt got=%b exp=000", {bus.i_gnt, bus.d_gnt, bus.ram_req});
      end
      vectors++;
      if ({bus.i_rvalid, bus.d_rvalid, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_rsp got=%b%b%b%b %h %h exp=0", bus.i_rvalid, bus.d_rvalid,
                 bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata);
      end
      advance();
    end
    rst_n = 1'b1;
    settle();
    vectors++;
    if ({bus.i_gnt, bus.d_gnt, bus.ram_req} !== 3'b011) begin
      miscompares++;
      $display("FAIL reset_first_grant got=%b exp=011", {bus.i_gnt, bus.d_gnt, bus.ram_req});
    end
    advance();
    drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0);
    settle();
    advance();
  endtask

  task automatic test_write_read();
    drive(0, 32'h0, 1, 32'h10, 1, 4'b0011, 32'hAABB_CCDD);
    settle();
    vectors++;
    if ({bus.d_gnt, bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata} !==
        {1'b1, 1'b1, 1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD}) begin
      miscompares++;
      $display("FAIL wr_cmd got=%b%b%b %b %h %h exp=111 0011 00000010 aabbccdd", bus.d_gnt,
               bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata);
    end
    advance();
    drive(0, 32'h0, 1, 32'h10, 0, 4'hF, 32'h0);
    settle();
    vectors++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata, bus.i_rvalid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL wr_rsp got=%b%b %h i_rvalid=%b exp=10 00000000 0", bus.d_rvalid, bus.d_err,
               bus.d_rdata, bus.i_rvalid);
    end
    advance();
    drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0);
    settle();
    vectors++;
    if ({bus.d_rvalid, bus.d_rdata[15:0]} !== {1'b1, 16'hCCDD} || bus.d_rdata !== exp_drd) begin
      miscompares++;
      $display("FAIL rd_after_wr got=%b %h exp=1 %h (low ccdd)", bus.d_rvalid, bus.d_rdata, exp_drd);
    end
    advance();
  endtask

  task automatic test_contention();
    int prev;
    prev = m_last;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1, 32'(k * 8), 1, 32'(k * 8 + 4), 0, 4'hF, 32'h0);
      else       drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0);
      settle();
      if (k < 4) begin
        vectors++;
        if ({bus.i_gnt, bus.d_gnt, bus.ram_req} !== {prev == 1, prev == 0, 1'b1}) begin
          miscompares++;
          $display("FAIL contention_gnt k=%0d got=%b exp=%b", k,
                   {bus.i_gnt, bus.d_gnt, bus.ram_req}, {prev == 1, prev == 0, 1'b1});
        end
        prev = 1 - prev;
      end
      if (k > 0) begin
        vectors++;
        if ({bus.i_rvalid, bus.d_rvalid, bus.i_rdata, bus.d_rdata} !==
            {exp_irv, exp_drv, exp_ird, exp_drd} || (bus.i_rvalid ^ bus.d_rvalid) !== 1'b1) begin
          miscompares++;
          $display("FAIL contention_rsp k=%0d got=%b%b %h %h exp=%b%b %h %h", k, bus.i_rvalid,
                   bus.d_rvalid, bus.i_rdata, bus.d_rdata, exp_irv, exp_drv, exp_ird, exp_drd);
        end
      end
      advance();
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2];
    addrs[0] = BASE + 32'(DEPTH * 4);
    addrs[1] = BASE + 32'(DEPTH * 4 - 4);
    for (int k = 0; k < 2; k++) begin
      drive(1, addrs[k], 0, 32'h0, 0, 4'h0, 32'h0);
      settle();
      vectors++;
      if ({bus.i_gnt, bus.ram_req} !== {1'b1, k == 1}) begin
        miscompares++;
        $display("FAIL oor_gnt addr=%h got=%b exp=%b", addrs[k], {bus.i_gnt, bus.ram_req}, {1'b1, k == 1});
      end
      advance();
      drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0);
      settle();
      vectors++;
      if ({bus.i_rvalid, bus.i_err} !== {1'b1, k == 0} || bus.i_rdata !== exp_ird ||
          (k == 0 && bus.i_rdata !== 32'h0)) begin
        miscompares++;
        $display("FAIL oor_rsp addr=%h got=%b%b %h exp=%b%b %h", addrs[k], bus.i_rvalid, bus.i_err,
                 bus.i_rdata, 1'b1, k == 0, exp_ird);
      end
      advance();
    end
  endtask

  task automatic test_reset_midop();
    drive(0, 32'h0, 1, 32'h20, 0, 4'hF, 32'h0);
    settle();
    advance();
    drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0);
    rst_n = 1'b0;
    settle();
    vectors++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.d_rdata} !== '0) begin
      miscompares++;
      $display("FAIL midop_in_reset got=%b%b %h exp=00 0", bus.i_rvalid, bus.d_rvalid, bus.d_rdata);
    end
    advance();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      vectors++;
      if ({bus.i_rvalid, bus.d_rvalid} !== 2'b00) begin
        miscompares++;
        $display("FAIL midop_after_release k=%0d got=%b exp=00", k, {bus.i_rvalid, bus.d_rvalid});
      end
      advance();
    end
  endtask

  task automatic test_streaming();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) drive(1, 32'(k * 4), 0, 32'h0, 0, 4'h0, 32'h0);
      else       drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0);
      settle();
      if (k < 8) begin
        vectors++;
        if ({bus.i_gnt, bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_addr} !==
            {1'b1, 1'b1, 1'b0, 4'hF, 32'(k * 4)}) begin
          miscompares++;
          $display("FAIL stream_cmd k=%0d got=%b%b%b %b %h", k, bus.i_gnt, bus.ram_req,
                   bus.ram_we, bus.ram_be, bus.ram_addr);
        end
      end
      if (k > 0) begin
        vectors++;
        if ({bus.i_rvalid, bus.i_rdata} !== {1'b1, ref_mem[k-1]}) begin
          miscompares++;
          $display("FAIL stream_rsp k=%0d got=%b %h exp=1 %h", k, bus.i_rvalid, bus.i_rdata, ref_mem[k-1]);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), rand_addr(),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      settle();
      vectors++;
      if ({bus.i_gnt, bus.d_gnt, bus.ram_req} !== {exp_ig, exp_dg, exp_rreq}) begin
        miscompares++;
        $display("FAIL rand_gnt n=%0d got=%b exp=%b", n, {bus.i_gnt, bus.d_gnt, bus.ram_req},
                 {exp_ig, exp_dg, exp_rreq});
      end
      if (exp_rreq) begin
        vectors++;
        if ({bus.ram_addr, bus.ram_we, bus.ram_be, bus.ram_wdata} !== {m_addr, m_we, m_be, m_wdata}) begin
          miscompares++;
          $display("FAIL rand_cmd n=%0d got=%h %b %b %h exp=%h %b %b %h", n, bus.ram_addr,
                   bus.ram_we, bus.ram_be, bus.ram_wdata, m_addr, m_we, m_be, m_wdata);
        end
      end
      vectors++;
      if ({bus.i_rvalid, bus.i_err, bus.i_rdata} !== {exp_irv, exp_ierr, exp_ird}) begin
        miscompares++;
        $display("FAIL rand_irsp n=%0d got=%b%b %h exp=%b%b %h", n, bus.i_rvalid, bus.i_err,
                 bus.i_rdata, exp_irv, exp_ierr, exp_ird);
      end
      vectors++;
      if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {exp_drv, exp_derr, exp_drd}) begin
        miscompares++;
        $display("FAIL rand_drsp n=%0d got=%b%b %h exp=%b%b %h", n, bus.d_rvalid, bus.d_err,
                 bus.d_rdata, exp_drv, exp_derr, exp_drd);
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    bus.ram_rdata = 32'h0;
    m_last = 0; p_valid = 0; p_owner = 0; p_err = 0; p_rdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      ram_mem[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_write_read();
    test_contention();
    test_out_of_range();
    test_reset_midop();
    test_streaming();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
